// File: rtl/core_bram_pkg.sv
// Shared types and helpers for the BRAM stream reader.
package core_bram_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bram_rd_state_e;

  // Modulo reduction for a single increment, so non-power-of-two depths wrap correctly.
  function automatic int unsigned addr_wrap(input int unsigned addr, input int unsigned depth);
    return (addr >= depth) ? addr - depth : addr;
  endfunction

endpackage

// File: rtl/core_skid_fifo.sv
// Small circular output buffer; push and pop may coincide at any occupancy.
module core_skid_fifo #(
  parameter int Width = 17,
  parameter int Depth = 2,
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] din_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [Depth-1:0][Width-1:0] mem_q;
  logic [PW-1:0]               rd_q, wr_q;
  logic [CW-1:0]               cnt_q;
  logic                        do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(Depth)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/core_bram_stream_reader.sv
// Sweeps a BRAM address window and streams each word out as valid/ready with last,
// hiding the 1-cycle read latency behind a small output buffer.
module core_bram_stream_reader
  import core_bram_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int Depth     = 1024,
  parameter int SkidDepth = 2,
  localparam int AW = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AW-1:0]        base_addr_i,
  input  logic [AW:0]          length_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AW-1:0]        bram_addr_o,
  input  logic [DataWidth-1:0] bram_data_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o,
  input  logic                 assert_on_i
);

  localparam int CW = $clog2(SkidDepth + 1);

  bram_rd_state_e state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW:0]    len_q, len_d, issued_q, issued_d;
  logic           inflight_q, inflight_d, infl_last_q, infl_last_d;
  logic           issue, pop;
  logic [CW-1:0]  occ;
  logic [DataWidth:0] head;

  core_skid_fifo #(.Width(DataWidth + 1), .Depth(SkidDepth)) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .din_i   ({infl_last_q, bram_data_i}),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (occ)
  );

  assign valid_o     = (occ != '0);
  assign pop         = valid_o && ready_i;
  assign data_o      = head[DataWidth-1:0];
  assign last_o      = head[DataWidth] && valid_o;
  assign bram_addr_o = addr_q;
  assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);

  // Issue only if the word will still have a slot when it lands next cycle.
  assign issue = (state_q == RUN) && (issued_q < len_q) &&
                 (32'(occ) + 32'(inflight_q) < 32'(SkidDepth) + 32'(pop));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    inflight_d  = issue;
    infl_last_d = (issued_q == len_q - (AW+1)'(1));
    unique case (state_q)
      IDLE: if (start_i) begin
        len_d    = length_i;
        addr_d   = base_addr_i;
        issued_d = '0;
        state_d  = (length_i == '0) ? DONE : RUN;
      end
      RUN: begin
        if (issue) begin
          addr_d   = AW'(addr_wrap(32'(addr_q) + 32'd1, Depth));
          issued_d = issued_q + (AW+1)'(1);
        end
        if (issued_q == len_q) state_d = DRAIN;
      end
      DRAIN: if (pop && last_o) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
    end
  end

  logic unused_assert_on;
  assign unused_assert_on = assert_on_i;

`ifdef ENABLE_SIMULATION_ASSERTS
  a_len: assert property (@(posedge clk_i) disable iff (rst_i || !assert_on_i)
    (state_q == IDLE && start_i) |-> (32'(length_i) <= 32'(Depth)));
  a_ovf: assert property (@(posedge clk_i) disable iff (rst_i || !assert_on_i)
    !(inflight_q && !pop && (32'(occ) == 32'(SkidDepth))));
  a_hold: assert property (@(posedge clk_i) disable iff (rst_i || !assert_on_i)
    (valid_o && !ready_i) |=> valid_o);
`endif

endmodule
